// File: rtl/operand_loader.sv
// Operand loader: pops 2*PORT_COUNT FIFO words into multiplier/multiplicand
// slot buses, then handshakes a single start pulse with the accelerator.
//
// state | meaning
// IDLE  | waiting for enable
// LOAD  | popping and capturing the words of one frame
// START | frame complete, waiting for acc_ready to issue mStart
// WAIT  | accelerator running; skip one cycle, then wait for acc_ready
module operand_loader #(
  parameter int BIT_LENGTH = 8,
  parameter int PORT_COUNT = 4,
  parameter int SIGNED     = 1
) (
  input  logic                                Clk,
  input  logic                                Rst,
  input  logic                                enable,
  input  logic                                EMPTY,
  input  logic [BIT_LENGTH-1:0]               fifo_dout,
  output logic                                rd_en,
  input  logic                                acc_ready,
  output logic                                mStart,
  output logic [PORT_COUNT*BIT_LENGTH*2-1:0]  multiplier_out,
  output logic [PORT_COUNT*BIT_LENGTH*2-1:0]  multiplicand_out,
  output logic                                busy,
  output logic [7:0]                          frame_count
);

  localparam int NW    = 2 * PORT_COUNT;
  localparam int CW    = $clog2(NW + 1);
  localparam int SW    = 2 * BIT_LENGTH;
  localparam int BUS_W = PORT_COUNT * SW;

  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;

  state_t            state;
  logic [CW-1:0]     req_cnt;
  logic [CW-1:0]     rcv_cnt;
  logic              data_valid;
  logic              wait_armed;
  logic [BUS_W-1:0]  mult_q;
  logic [BUS_W-1:0]  mcand_q;
  logic [SW-1:0]     word_ext;

  generate
    if (SIGNED != 0) begin : g_sext
      assign word_ext = {{BIT_LENGTH{fifo_dout[BIT_LENGTH-1]}}, fifo_dout};
    end else begin : g_zext
      assign word_ext = {{BIT_LENGTH{1'b0}}, fifo_dout};
    end
  endgenerate

  // Gated by Rst so no word is popped or start issued on a reset edge.
  assign rd_en  = !Rst && (state == LOAD) && !EMPTY && (req_cnt < CW'(NW));
  assign mStart = !Rst && (state == START) && acc_ready;
  assign busy   = (state != IDLE);

  assign multiplier_out   = mult_q;
  assign multiplicand_out = mcand_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      req_cnt     <= '0;
      rcv_cnt     <= '0;
      data_valid  <= 1'b0;
      wait_armed  <= 1'b0;
      frame_count <= 8'd0;
      mult_q      <= '0;
      mcand_q     <= '0;
    end else begin
      data_valid <= rd_en;
      if (rd_en)
        req_cnt <= req_cnt + CW'(1);

      if (data_valid) begin
        for (int k = 0; k < PORT_COUNT; k++) begin
          if (rcv_cnt == CW'(k))
            mult_q[k*SW +: SW] <= word_ext;
          if (rcv_cnt == CW'(k + PORT_COUNT))
            mcand_q[k*SW +: SW] <= word_ext;
        end
        rcv_cnt <= rcv_cnt + CW'(1);
      end

      case (state)
        IDLE: begin
          if (enable) begin
            state   <= LOAD;
            req_cnt <= '0;
            rcv_cnt <= '0;
          end
        end
        LOAD: begin
          if (data_valid && (rcv_cnt == CW'(NW - 1)))
            state <= START;
        end
        START: begin
          if (acc_ready) begin
            state       <= WAIT;
            wait_armed  <= 1'b0;
            frame_count <= frame_count + 8'd1;
          end
        end
        WAIT: begin
          // acc_ready may still reflect the previous run in the first cycle
          if (!wait_armed)
            wait_armed <= 1'b1;
          else if (acc_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 SHALL have parameter BIT_LENGTH, default 8, meaning the width of one FIFO word.
REQ-002 SHALL have parameter PORT_COUNT, default 4, meaning the number of operand slots per operand bus.
REQ-003 SHALL have parameter SIGNED, default 1, meaning 1 = sign-extend words into slots and 0 = zero-extend.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports named Clk and Rst.
REQ-005 SHALL have the following ports (name, direction, width, meaning):
- Clk  in  1  clock; all state updates on its rising edge.
- Rst  in  1  synchronous active-high reset.
- enable  in  1  level; permits a new frame load from IDLE.
- EMPTY  in  1  input FIFO empty flag.
- fifo_dout  in  BIT_LENGTH  FIFO read data, valid the cycle after rd_en.
- rd_en  out  1  FIFO pop request.
- acc_ready  in  1  accelerator idle/done level.
- mStart  out  1  one-cycle accelerator start pulse.
- multiplier_out  out  PORT_COUNT*BIT_LENGTH*2  packed multiplier slots.
- multiplicand_out  out  PORT_COUNT*BIT_LENGTH*2  packed multiplicand slots.
- busy  out  1  high in any state other than IDLE.
- frame_count  out  8  count of completed frames; wraps from 255 to 0.

Function
REQ-006 SHALL define a frame as 2*PORT_COUNT consecutive FIFO words: words 0..PORT_COUNT-1 go to multiplier slots 0..PORT_COUNT-1, and the remaining words go to multiplicand slots 0..PORT_COUNT-1.
REQ-007 SHALL place slot k at bits [k*2*BIT_LENGTH +: 2*BIT_LENGTH], with each word extended to 2*BIT_LENGTH per the SIGNED parameter.
REQ-008 SHALL implement the states IDLE, LOAD, START and WAIT.
REQ-009 SHALL transition IDLE->LOAD when enable=1, and otherwise hold IDLE.
REQ-010 SHALL, in LOAD, assert rd_en combinationally when EMPTY=0 and req_cnt<2*PORT_COUNT; req_cnt increments on each rd_en cycle.
REQ-011 SHALL never assert rd_en while EMPTY=1 or outside LOAD.
REQ-012 SHALL register rd_en as data_valid; on data_valid it captures fifo_dout into slot rcv_cnt and increments rcv_cnt.
REQ-013 SHALL sustain one word per cycle when the FIFO is non-empty, with no bubbles.
REQ-014 SHALL transition LOAD->START on the cycle after the capture of word 2*PORT_COUNT-1.
REQ-015 SHALL, in START, assert mStart for exactly one cycle when acc_ready=1, and otherwise hold START with mStart=0.
REQ-016 SHALL transition START->WAIT in the cycle that mStart is asserted, and increment frame_count in that same cycle.
REQ-017 SHALL, in WAIT, ignore acc_ready in the first cycle, then return to IDLE on the first cycle with acc_ready=1.
REQ-018 SHALL hold both operand buses stable outside LOAD; slots of a new frame are overwritten one by one as they are captured.
REQ-019 SHALL clear req_cnt and rcv_cnt on entering LOAD.
REQ-020 SHALL let enable deasserting mid-frame have no effect; the frame completes.
REQ-021 SHALL stall LOAD with no timeout if EMPTY asserts mid-frame, resuming when EMPTY=0.
REQ-022 SHALL allow a word captured on the same cycle that the final rd_en is issued (pipeline overlap); req_cnt and rcv_cnt count independently.

Reset
REQ-023 SHALL, on Rst=1 at a clock edge, set state=IDLE, rd_en=0, mStart=0, busy=0, frame_count=0, req_cnt=rcv_cnt=0, data_valid=0, and both operand buses to all zeros.
REQ-024 SHALL, on reset mid-LOAD, discard the partial frame; words already popped are lost and no mStart is issued.
REQ-025 SHALL give Rst priority over all other inputs.

Verification (BIT_LENGTH=8, PORT_COUNT=4, SIGNED=1)
REQ-026 SHALL cover: FIFO preloaded with 01..08, enable=1, acc_ready=1 -> rd_en high 8 consecutive cycles; multiplier_out=0x0004_0003_0002_0001, multiplicand_out=0x0008_0007_0006_0005; mStart pulses once; frame_count=1.
REQ-027 SHALL cover: words 0xFF and 0x80 in slot 0 of each bus -> slot values 0xFFFF and 0xFF80; with SIGNED=0 -> 0x00FF and 0x0080.
REQ-028 SHALL cover: EMPTY asserted after 3 words for 5 cycles -> no rd_en while EMPTY=1; the frame completes with correct slot order.
REQ-029 SHALL cover: acc_ready=0 in START for 10 cycles -> mStart stays 0, then a single pulse on the first cycle with acc_ready=1; busy=1 throughout.
REQ-030 SHALL cover: Rst pulsed after 5 words captured -> all outputs zero the next cycle; a subsequent full frame loads correctly with frame_count=1.
REQ-031 SHALL cover: 256 back-to-back frames -> frame_count wraps to 0.
